// File: rtl/vga_plot_arbiter_if.sv
// Pixel request bus (NUM_CH packed requesters) and the registered plot port
// that feeds vga_adapter.
interface vga_plot_arbiter_if #(
  parameter int NUM_CH   = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 18
);
  logic [NUM_CH-1:0]          req_valid;
  logic [NUM_CH-1:0]          req_ready;
  logic [NUM_CH*X_W-1:0]      req_x;
  logic [NUM_CH*Y_W-1:0]      req_y;
  logic [NUM_CH*COLOUR_W-1:0] req_colour;
  logic [X_W-1:0]             vga_x;
  logic [Y_W-1:0]             vga_y;
  logic [COLOUR_W-1:0]        vga_colour;
  logic                       vga_write;

  modport slave (
    input  req_valid, req_x, req_y, req_colour,
    output req_ready, vga_x, vga_y, vga_colour, vga_write
  );

  modport master (
    output req_valid, req_x, req_y, req_colour,
    input  req_ready, vga_x, vga_y, vga_colour, vga_write
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin pixel-write arbiter for vga_adapter with a hardware full-screen
// clear sweep and out-of-range request dropping.
module vga_plot_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 18,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_busy,
  output logic [15:0]         drop_count,
  vga_plot_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(NUM_CH);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                vga_write_q, vga_write_d;
  logic                clear_busy_q, clear_busy_d;
  logic [15:0]         drop_q, drop_d;
  logic [X_W-1:0]      cx_q, cx_d;
  logic [Y_W-1:0]      cy_q, cy_d;
  logic [COLOUR_W-1:0] ccol_q, ccol_d;

  logic [X_W-1:0]      ch_x   [NUM_CH];
  logic [Y_W-1:0]      ch_y   [NUM_CH];
  logic [COLOUR_W-1:0] ch_col [NUM_CH];

  logic                grant_found;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    cand;
  logic                grant_in_range;
  logic [NUM_CH-1:0]   ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_x[gi]   = bus.req_x[gi*X_W +: X_W];
    assign ch_y[gi]   = bus.req_y[gi*Y_W +: Y_W];
    assign ch_col[gi] = bus.req_colour[gi*COLOUR_W +: COLOUR_W];
  end

  // First valid channel at or after the round-robin pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = PTR_W'((int'(rr_q) + k) % NUM_CH);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_in_range = (ch_x[grant_idx] <= X_W'(X_MAX)) &&
                          (ch_y[grant_idx] <= Y_W'(Y_MAX));

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_write_d  = 1'b0;
    clear_busy_d = clear_busy_q;
    drop_d       = drop_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    ccol_d       = ccol_q;
    ready        = '0;
    case (state_q)
      ST_ARB: begin
        if (clear_req) begin
          ccol_d       = clear_colour;
          cx_d         = '0;
          cy_d         = '0;
          clear_busy_d = 1'b1;
          state_d      = ST_CLEAR;
        end else if (grant_found) begin
          ready[grant_idx] = 1'b1;
          rr_d = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
          if (grant_in_range) begin
            vga_x_d      = ch_x[grant_idx];
            vga_y_d      = ch_y[grant_idx];
            vga_colour_d = ch_col[grant_idx];
            vga_write_d  = 1'b1;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      ST_CLEAR: begin
        vga_x_d      = cx_q;
        vga_y_d      = cy_q;
        vga_colour_d = ccol_q;
        vga_write_d  = 1'b1;
        if (cx_q == X_W'(X_MAX)) begin
          cx_d = '0;
          if (cy_q == Y_W'(Y_MAX)) begin
            cy_d         = '0;
            clear_busy_d = 1'b0;
            state_d      = ST_ARB;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_ARB;
      rr_q         <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_write_q  <= 1'b0;
      clear_busy_q <= 1'b0;
      drop_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      ccol_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_write_q  <= vga_write_d;
      clear_busy_q <= clear_busy_d;
      drop_q       <= drop_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      ccol_q       <= ccol_d;
    end
  end

  // Ready is combinational, so hold it low explicitly while in reset.
  assign bus.req_ready  = resetn ? ready : '0;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_write  = vga_write_q;
  assign clear_busy     = clear_busy_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: a reference model queues expected
// plot writes, a separate monitor pops and compares them.
module tb_vga_plot_arbiter;

  localparam int NUM_CH   = 4;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 18;
  localparam int X_MAX    = 159;
  localparam int Y_MAX    = 119;
  localparam int NPIX     = (X_MAX + 1) * (Y_MAX + 1);

  typedef struct {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] c;
    int                  cyc;
  } pix_t;

  logic                clock;
  logic                resetn;
  logic                clear_req;
  logic [COLOUR_W-1:0] clear_colour;
  logic                clear_busy;
  logic [15:0]         drop_count;

  vga_plot_arbiter_if #(.NUM_CH(NUM_CH), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

  vga_plot_arbiter #(
    .NUM_CH(NUM_CH), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W),
    .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .drop_count   (drop_count),
    .bus          (bus)
  );

  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  pix_t sb[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Reference model: round-robin grant, range check, clear sweep timing.
  int                  m_ptr = 0;
  int                  m_clr_left = 0;
  logic [15:0]         m_drop = '0;
  logic [NUM_CH-1:0]   exp_rdy;
  int                  g;
  int                  cidx;
  pix_t                p;

  initial forever begin
    @(negedge clock);
    if (!resetn) begin
      m_ptr = 0;
      m_drop = '0;
      m_clr_left = 0;
      sb.delete();
      n_total++;
      if (bus.req_ready !== '0) begin
        n_bad++;
        $display("FAIL ready_in_reset cyc=%0d got=%b want=0", cyc, bus.req_ready);
      end
    end else begin
      exp_rdy = '0;
      g = -1;
      if (m_clr_left == 0 && !clear_req) begin
        for (int k = 0; k < NUM_CH; k++) begin
          cidx = (m_ptr + k) % NUM_CH;
          if (g < 0 && bus.req_valid[cidx]) g = cidx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      n_total++;
      if (bus.req_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, exp_rdy);
      end
      n_total++;
      if (drop_count !== m_drop) begin
        n_bad++;
        $display("FAIL drop_count cyc=%0d got=%h want=%h", cyc, drop_count, m_drop);
      end
      n_total++;
      if (clear_busy !== (m_clr_left > 0)) begin
        n_bad++;
        $display("FAIL clear_busy cyc=%0d got=%b want=%b", cyc, clear_busy, m_clr_left > 0);
      end
      if (m_clr_left > 0) begin
        m_clr_left--;
      end else if (clear_req) begin
        m_clr_left = NPIX;
        for (int k = 0; k < NPIX; k++) begin
          p.x = X_W'(k % (X_MAX + 1));
          p.y = Y_W'(k / (X_MAX + 1));
          p.c = clear_colour;
          p.cyc = cyc + 2 + k;
          sb.push_back(p);
        end
      end else if (g >= 0) begin
        p.x = bus.req_x[g*X_W +: X_W];
        p.y = bus.req_y[g*Y_W +: Y_W];
        p.c = bus.req_colour[g*COLOUR_W +: COLOUR_W];
        p.cyc = cyc + 1;
        if (int'(p.x) <= X_MAX && int'(p.y) <= Y_MAX) sb.push_back(p);
        else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        m_ptr = (g + 1) % NUM_CH;
      end
    end
  end

  // Monitor: every plot write must match the oldest expected pixel, on time.
  pix_t e;
  initial forever begin
    @(negedge clock);
    if (resetn) begin
      if (bus.vga_write === 1'b1) begin
        n_total++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write cyc=%0d got x=%0d y=%0d c=%h want no write",
                   cyc, bus.vga_x, bus.vga_y, bus.vga_colour);
        end else begin
          e = sb.pop_front();
          if (bus.vga_x !== e.x || bus.vga_y !== e.y || bus.vga_colour !== e.c || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL pixel cyc=%0d got x=%0d y=%0d c=%h want x=%0d y=%0d c=%h at cyc=%0d",
                     cyc, bus.vga_x, bus.vga_y, bus.vga_colour, e.x, e.y, e.c, e.cyc);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        n_total++;
        n_bad++;
        e = sb.pop_front();
        $display("FAIL missing_write cyc=%0d got write=%b want x=%0d y=%0d c=%h",
                 cyc, bus.vga_write, e.x, e.y, e.c);
      end
    end
  end

  // Driver
  logic [NUM_CH-1:0] acc;

  task automatic step();
    @(negedge clock);
    acc = bus.req_ready & bus.req_valid;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int ch, input bit v, input int x, input int y, input int c);
    bus.req_valid[ch] = v;
    bus.req_x[ch*X_W +: X_W] = X_W'(x);
    bus.req_y[ch*Y_W +: Y_W] = Y_W'(y);
    bus.req_colour[ch*COLOUR_W +: COLOUR_W] = COLOUR_W'(c);
  endtask

  task automatic rand_fill(input int pct, input int xmax, input int ymax);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!bus.req_valid[ch] || acc[ch]) begin
        if (int'($urandom_range(99)) < pct)
          set_req(ch, 1'b1, int'($urandom_range(xmax)), int'($urandom_range(ymax)),
                  int'($urandom_range((1 << COLOUR_W) - 1)));
        else
          bus.req_valid[ch] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_req = 1'b0;
    bus.req_valid = '0;
    acc = '0;
    repeat (2) step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    clear_req = 1'b0;
    clear_colour = '0;
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_colour = '0;
    acc = '0;
    #1;
    do_reset();
    repeat (10) step();

    set_req(2, 1'b1, 10, 20, 'h3F000);
    step();
    bus.req_valid = '0;
    repeat (3) step();

    do_reset();
    repeat (12) begin
      rand_fill(100, X_MAX, Y_MAX);
      step();
    end
    bus.req_valid = '0;
    repeat (2) step();

    repeat (1000) begin
      rand_fill(60, X_MAX + 10, Y_MAX + 8);
      step();
    end
    bus.req_valid = '0;
    repeat (2) step();

    do_reset();
    set_req(1, 1'b1, 160, 5, 'h12345);
    step();
    bus.req_valid = '0;
    repeat (2) step();
    set_req(0, 1'b1, 200, 100, 'h3FFFF);
    repeat (65540) step();
    bus.req_valid = '0;
    repeat (3) step();

    set_req(0, 1'b1, 33, 44, 'h2AAAA);
    clear_colour = 'h00FC0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    clear_colour = COLOUR_W'($urandom_range((1 << COLOUR_W) - 1));
    for (int k = 0; k < NPIX + 20 && !acc[0]; k++) step();
    n_total++;
    if (!acc[0]) begin
      n_bad++;
      $display("FAIL post_clear_grant got no grant of ch0 want grant after sweep");
    end
    bus.req_valid = '0;
    repeat (3) step();

    clear_colour = 'h15555;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (501) step();
    #1 resetn = 1'b0;
    #1;
    n_total++;
    if (bus.vga_x !== '0 || bus.vga_y !== '0 || bus.vga_colour !== '0 || bus.vga_write !== 1'b0 ||
        clear_busy !== 1'b0 || drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL async_reset got x=%0d y=%0d c=%h w=%b busy=%b drop=%h want all zero",
               bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_write, clear_busy, drop_count);
    end
    step();
    resetn = 1'b1;
    repeat (10) step();
    repeat (60) begin
      rand_fill(70, X_MAX + 4, Y_MAX + 4);
      step();
    end
    bus.req_valid = '0;
    repeat (4) step();

    n_total++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expected got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
